multicycle_cu: RTL and testbench

Multi-cycle control unit that sequences the existing RV32I datapath: pc, sum, instruction memory, register file, imm, ALU, Branch, data memory and the four operand/writeback muxes. Each instruction takes several cycles, and a single FSM drives every enable and mux select. The block adds a stall input, halt-on-ECALL, illegal-opcode reporting and a retired-instruction counter. It replaces the per-edge opcode decode with registered instruction fields.

---
 rtl/multicycle_pkg.sv | 40 ++++
 rtl/multicycle_decode.sv | 49 ++++
 rtl/multicycle_cu.sv | 167 ++++++++++++++++
 tb/tb_multicycle_cu.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit:
// opcodes, FSM states, instruction classes and mux select values.
package multicycle_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_R,
    C_I,
    C_LOAD,
    C_STORE,
    C_BRANCH,
    C_JAL,
    C_ECALL,
    C_ILLEGAL
  } cls_t;

  localparam logic [1:0] WB_DM  = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_SUM = 2'b10;

  localparam logic PC_SUM = 1'b0;
  localparam logic PC_ALU = 1'b1;

endpackage

// File: rtl/multicycle_decode.sv
// Opcode to instruction class, and class to operand/writeback selects.
module multicycle_decode
  import multicycle_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [2:0] cls,
  input  logic [2:0] cur,
  output logic       op1_sel,
  output logic       op2_sel,
  output logic [1:0] wb_sel
);

  cls_t c;
  cls_t k;

  assign k   = cls_t'(cur);
  assign cls = c;

  always_comb begin
    c = C_ILLEGAL;
    unique case (1'b1)
      opcode == OP_R:      c = C_R;
      opcode == OP_I:      c = C_I;
      opcode == OP_LOAD:   c = C_LOAD;
      opcode == OP_STORE:  c = C_STORE;
      opcode == OP_BRANCH: c = C_BRANCH;
      opcode == OP_JAL:    c = C_JAL;
      opcode == OP_SYSTEM: c = C_ECALL;
      default:             c = C_ILLEGAL;
    endcase
  end

  always_comb begin
    op1_sel = 1'b1;
    op2_sel = 1'b1;
    wb_sel  = WB_ALU;
    unique case (k)
      C_R:      op2_sel = 1'b0;
      C_LOAD:   wb_sel  = WB_DM;
      C_BRANCH: op1_sel = 1'b0;
      C_JAL: begin
        op1_sel = 1'b0;
        wb_sel  = WB_SUM;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_cu.sv
// Multi-cycle RV32I control unit: one FSM drives every datapath
// enable and select; adds stall, ECALL halt and a retire counter.
module multicycle_cu
  import multicycle_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  instr,
  input  logic             branch_taken,
  input  logic             stall,
  output logic             ir_wenable,
  output logic             pc_wenable,
  output logic             pc_sel,
  output logic             rf_wenable,
  output logic             dm_wenable,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic [2:0]       func3,
  output logic             subsra,
  output logic             op1_sel,
  output logic             op2_sel,
  output logic [1:0]       wb_sel,
  output logic [4:0]       br_op,
  output logic             illegal,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  state_t     state;
  state_t     next;
  cls_t       cls;
  cls_t       fetch_cls;
  logic [2:0] dec_cls;
  logic       dec_op1;
  logic       dec_op2;
  logic [1:0] dec_wb;
  logic       sel_on;
  logic       retire;
  logic       unused;

  assign unused    = ^{instr[XLEN-1:31], instr[29:25]};
  assign fetch_cls = cls_t'(dec_cls);

  multicycle_decode u_dec (
    .opcode  (instr[6:0]),
    .cls     (dec_cls),
    .cur     (cls),
    .op1_sel (dec_op1),
    .op2_sel (dec_op2),
    .wb_sel  (dec_wb)
  );

  always_comb begin
    next       = state;
    ir_wenable = 1'b0;
    pc_wenable = 1'b0;
    pc_sel     = PC_SUM;
    rf_wenable = 1'b0;
    dm_wenable = 1'b0;
    illegal    = 1'b0;
    retire     = 1'b0;
    sel_on     = 1'b0;
    unique case (state)
      S_FETCH: begin
        ir_wenable = 1'b1;
        next       = S_DECODE;
      end
      S_DECODE: begin
        if (cls == C_ECALL) begin
          retire = 1'b1;
          next   = S_HALT;
        end else if (cls == C_ILLEGAL) begin
          illegal    = 1'b1;
          pc_wenable = 1'b1;
          next       = S_FETCH;
        end else begin
          next = S_EXEC;
        end
      end
      S_EXEC: begin
        sel_on = 1'b1;
        if (cls == C_BRANCH) begin
          pc_wenable = 1'b1;
          pc_sel     = branch_taken;
          retire     = 1'b1;
          next       = S_FETCH;
        end else if (cls == C_LOAD || cls == C_STORE) begin
          next = S_MEM;
        end else begin
          next = S_WB;
        end
      end
      S_MEM: begin
        sel_on = 1'b1;
        if (cls == C_STORE) begin
          dm_wenable = 1'b1;
          pc_wenable = 1'b1;
          retire     = 1'b1;
          next       = S_FETCH;
        end else begin
          next = S_WB;
        end
      end
      S_WB: begin
        sel_on     = 1'b1;
        rf_wenable = 1'b1;
        pc_wenable = 1'b1;
        pc_sel     = (cls == C_JAL) ? PC_ALU : PC_SUM;
        retire     = 1'b1;
        next       = S_FETCH;
      end
      S_HALT: next = S_HALT;
      default: next = S_FETCH;
    endcase
    // a stalled cycle repeats later, so nothing may commit now
    if (stall || reset) begin
      ir_wenable = 1'b0;
      pc_wenable = 1'b0;
      rf_wenable = 1'b0;
      dm_wenable = 1'b0;
      illegal    = 1'b0;
      retire     = 1'b0;
    end
    if (reset) begin
      sel_on = 1'b0;
      pc_sel = PC_SUM;
    end
  end

  assign op1_sel = sel_on ? dec_op1 : 1'b0;
  assign op2_sel = sel_on ? dec_op2 : 1'b0;
  assign wb_sel  = sel_on ? dec_wb : WB_ALU;
  assign br_op   = (sel_on && cls == C_BRANCH) ? {2'b00, func3} : 5'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      cls     <= C_ILLEGAL;
      rs1     <= '0;
      rs2     <= '0;
      rd      <= '0;
      func3   <= '0;
      subsra  <= 1'b0;
      halted  <= 1'b0;
      retired <= '0;
    end else if (!stall) begin
      state <= next;
      if (ir_wenable) begin
        cls    <= fetch_cls;
        rs1    <= instr[19:15];
        rs2    <= (fetch_cls == C_I || fetch_cls == C_LOAD) ?
                  5'd0 : instr[24:20];
        rd     <= (fetch_cls == C_STORE || fetch_cls == C_BRANCH) ?
                  5'd0 : instr[11:7];
        func3  <= instr[14:12];
        subsra <= (fetch_cls == C_R) && instr[30];
      end
      if (retire) retired <= retired + CNT_W'(1);
      if (next == S_HALT) halted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_cu.sv
// Randomised bench for multicycle_cu against a per-instruction
// latency/effect model derived from the instruction class.
module tb_multicycle_cu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr = 32'h13;
  logic        branch_taken = 1'b0;
  logic        stall = 1'b0;
  logic        ir_wenable, pc_wenable, pc_sel, rf_wenable, dm_wenable;
  logic [4:0]  rs1, rs2, rd, br_op;
  logic [2:0]  func3;
  logic        subsra, op1_sel, op2_sel, illegal, halted;
  logic [1:0]  wb_sel;
  logic [3:0]  retired;

  always #5 clk = ~clk;

  multicycle_cu #(.XLEN(32), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .instr(instr),
    .branch_taken(branch_taken), .stall(stall),
    .ir_wenable(ir_wenable), .pc_wenable(pc_wenable),
    .pc_sel(pc_sel), .rf_wenable(rf_wenable),
    .dm_wenable(dm_wenable), .rs1(rs1), .rs2(rs2), .rd(rd),
    .func3(func3), .subsra(subsra), .op1_sel(op1_sel),
    .op2_sel(op2_sel), .wb_sel(wb_sel), .br_op(br_op),
    .illegal(illegal), .halted(halted), .retired(retired)
  );

  int total = 0;
  int bad = 0;
  int model_ret = 0;

  logic [31:0] prog_q[$];
  bit          bt_q[$];
  string       nm_q[$];
  int          act_q[$];
  int          exp_q[$];

  // class index: 0 R, 1 I, 2 LOAD, 3 STORE, 4 BR, 5 JAL, 6 ECALL, 7 ILL
  int lat_tab[8] = '{4, 4, 5, 4, 3, 4, 2, 2};
  logic [6:0] ok_ops[6] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F};
  logic [6:0] bad_ops[6] = '{7'h7F, 7'h37, 7'h17, 7'h67, 7'h0F, 7'h00};

  typedef struct packed {
    int cycles; int rf_n; int dm_n; int pc_n; int ill_n;
    int stall_en; int rf_cyc; int dm_cyc; int pc_cyc;
    logic pcs; logic [1:0] wb; logic op1; logic op2;
    logic [4:0] br; logic sub;
    logic [4:0] rs1; logic [4:0] rs2; logic [4:0] rd;
    logic [2:0] f3; logic [3:0] ret; logic hlt;
  } obs_t;

  function automatic int kind(input logic [31:0] ins);
    case (ins[6:0])
      7'h33: return 0;
      7'h13: return 1;
      7'h03: return 2;
      7'h23: return 3;
      7'h63: return 4;
      7'h6F: return 5;
      7'h73: return 6;
      default: return 7;
    endcase
  endfunction

  function automatic obs_t model(input logic [31:0] ins, input bit bt,
                                 input int ret_before);
    obs_t e;
    int k;
    k = kind(ins);
    e = '0;
    e.cycles = lat_tab[k];
    e.rf_n   = (k <= 2 || k == 5) ? 1 : 0;
    e.rf_cyc = (e.rf_n != 0) ? e.cycles : 0;
    e.dm_n   = (k == 3) ? 1 : 0;
    e.dm_cyc = (e.dm_n != 0) ? e.cycles : 0;
    e.pc_n   = (k != 6) ? 1 : 0;
    e.pc_cyc = (e.pc_n != 0) ? e.cycles : 0;
    e.ill_n  = (k == 7) ? 1 : 0;
    e.pcs    = (k == 4) ? bt : (k == 5);
    e.wb     = (k == 2) ? 2'b00 : (k == 5) ? 2'b10 :
               (e.rf_n != 0) ? 2'b01 : 2'b11;
    e.op1    = !(k == 4 || k == 5);
    e.op2    = (k != 0);
    e.br     = (k == 4) ? {2'b00, ins[14:12]} : 5'd0;
    e.sub    = (k == 0) && ins[30];
    e.rs1    = ins[19:15];
    e.rs2    = (k == 1 || k == 2) ? 5'd0 : ins[24:20];
    e.rd     = (k == 3 || k == 4) ? 5'd0 : ins[11:7];
    e.f3     = ins[14:12];
    e.ret    = 4'((ret_before + ((k != 7) ? 1 : 0)) % 16);
    e.hlt    = (k == 6);
    return e;
  endfunction

  function automatic void rec(input string n, input int a, input int e);
    nm_q.push_back(n);
    act_q.push_back(a);
    exp_q.push_back(e);
  endfunction

  function automatic void clr();
    nm_q.delete();
    act_q.delete();
    exp_q.delete();
  endfunction

  // Observe one instruction from its FETCH cycle until the next FETCH or HALT.
  task automatic run_instr(input logic [31:0] ins, input bit bt,
                           input bit rnd_stall, output obs_t o);
    int c;
    c = 0;
    o = '0;
    o.wb = 2'b11;
    instr = ins;
    branch_taken = bt;
    for (int k = 0; k < 40; k++) begin
      stall = rnd_stall && (k > 0) && ($urandom_range(0, 3) == 0);
      #1;
      if (stall) begin
        if ({ir_wenable, pc_wenable, rf_wenable, dm_wenable, illegal} != 0)
          o.stall_en++;
      end else begin
        c++;
        if (c == 2) begin
          o.rs1 = rs1; o.rs2 = rs2; o.rd = rd;
          o.f3 = func3; o.sub = subsra;
        end
        if (rf_wenable) begin o.rf_n++; o.rf_cyc = c; o.wb = wb_sel; end
        if (dm_wenable) begin o.dm_n++; o.dm_cyc = c; end
        if (illegal) o.ill_n++;
        if (pc_wenable) begin
          o.pc_n++; o.pc_cyc = c; o.pcs = pc_sel;
          o.op1 = op1_sel; o.op2 = op2_sel; o.br = br_op;
        end
      end
      @(posedge clk); #1;
      stall = 1'b0;
      #1;
      if (ir_wenable || halted) begin
        o.cycles = c;
        break;
      end
    end
    o.ret = retired;
    o.hlt = halted;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    stall = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
    #1;
    model_ret = 0;
  endtask

  task automatic test_reset();
    clr();
    reset = 1'b1;
    stall = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rec("rst_enables", int'({ir_wenable, pc_wenable, rf_wenable, dm_wenable,
        pc_sel, illegal, halted}), 0);
    rec("rst_selects", int'({op1_sel, op2_sel, wb_sel}), 1);
    rec("rst_fields", int'({rs1, rs2, rd, func3, subsra, br_op}), 0);
    rec("rst_retired", int'(retired), 0);
    reset = 1'b0;
    #1;
    model_ret = 0;
    rec("rst_fetch", int'(ir_wenable), 1);
    for (int i = 0; i < nm_q.size(); i++) begin
      total++;
      if (act_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL %s: got %0d want %0d", nm_q[i], act_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_program(input string name, input bit rnd_stall);
    obs_t o, e;
    int k;
    for (int n = 0; n < prog_q.size(); n++) begin
      clr();
      k = kind(prog_q[n]);
      e = model(prog_q[n], bt_q[n], model_ret);
      run_instr(prog_q[n], bt_q[n], rnd_stall, o);
      model_ret = int'(e.ret);
      rec("cycles", o.cycles, e.cycles);
      rec("rf_n", o.rf_n, e.rf_n);
      rec("rf_cyc", o.rf_cyc, e.rf_cyc);
      rec("dm_n", o.dm_n, e.dm_n);
      rec("dm_cyc", o.dm_cyc, e.dm_cyc);
      rec("pc_n", o.pc_n, e.pc_n);
      rec("ill_n", o.ill_n, e.ill_n);
      rec("stall_en", o.stall_en, 0);
      rec("wb_sel", int'(o.wb), int'(e.wb));
      rec("rs1", int'(o.rs1), int'(e.rs1));
      rec("rs2", int'(o.rs2), int'(e.rs2));
      rec("rd", int'(o.rd), int'(e.rd));
      rec("func3", int'(o.f3), int'(e.f3));
      rec("subsra", int'(o.sub), int'(e.sub));
      rec("retired", int'(o.ret), int'(e.ret));
      rec("halted", int'(o.hlt), int'(e.hlt));
      if (k != 6) begin
        rec("pc_cyc", o.pc_cyc, e.pc_cyc);
        rec("pc_sel", int'(o.pcs), int'(e.pcs));
        rec("br_op", int'(o.br), int'(e.br));
      end
      if (k < 6) begin
        rec("op1_sel", int'(o.op1), int'(e.op1));
        rec("op2_sel", int'(o.op2), int'(e.op2));
      end
      for (int i = 0; i < nm_q.size(); i++) begin
        total++;
        if (act_q[i] !== exp_q[i]) begin
          bad++;
          $display("FAIL %s #%0d (%h) %s: got %0d want %0d",
                   name, n, prog_q[n], nm_q[i], act_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_directed();
    prog_q = '{32'h002081B3, 32'h402081B3, 32'h0080A283, 32'h0020A223,
               32'h00208463, 32'h00208463, 32'h008000EF, 32'h00508093,
               32'h0000007F};
    bt_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    test_program("directed", 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] r;
    int c;
    prog_q.delete();
    bt_q.delete();
    for (int i = 0; i < 60; i++) begin
      r = $urandom;
      c = $urandom_range(0, 6);
      if (c < 6) prog_q.push_back({r[31:7], ok_ops[c]});
      else prog_q.push_back({r[31:7], bad_ops[$urandom_range(0, 5)]});
      bt_q.push_back(1'($urandom_range(0, 1)));
    end
    test_program("random", 1'b1);
  endtask

  task automatic test_stall_store();
    int en_n, dm_tot, first, done;
    clr();
    instr = 32'h0020A223;
    branch_taken = 1'b0;
    stall = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    stall = 1'b1;
    en_n = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      if ({ir_wenable, pc_wenable, rf_wenable, dm_wenable} != 0) en_n++;
      @(posedge clk); #1;
    end
    stall = 1'b0;
    #1;
    first = int'(dm_wenable);
    dm_tot = 0;
    done = 0;
    for (int k = 0; k < 6; k++) begin
      if (dm_wenable) dm_tot++;
      @(posedge clk); #1;
      if (ir_wenable) begin done = 1; break; end
    end
    model_ret = (model_ret + 1) % 16;
    rec("stall_en", en_n, 0);
    rec("stall_dm_first", first, 1);
    rec("stall_dm_total", dm_tot, 1);
    rec("stall_done", done, 1);
    rec("stall_retired", int'(retired), model_ret);
    for (int i = 0; i < nm_q.size(); i++) begin
      total++;
      if (act_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL %s: got %0d want %0d", nm_q[i], act_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int ret0;
    clr();
    ret0 = int'(retired);
    instr = 32'h00208463;
    branch_taken = 1'b1;
    stall = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    rec("mid_enables", int'({ir_wenable, pc_wenable, rf_wenable,
        dm_wenable}), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    model_ret = 0;
    rec("mid_fetch", int'(ir_wenable), 1);
    rec("mid_retired", int'(retired), 0);
    rec("mid_rd", int'(rd), 0);
    rec("mid_before", ret0, model_ret + ret0);
    for (int i = 0; i < nm_q.size(); i++) begin
      total++;
      if (act_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL %s: got %0d want %0d", nm_q[i], act_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    prog_q.delete();
    bt_q.delete();
    for (int i = 0; i < 17; i++) begin
      prog_q.push_back(32'h002081B3);
      bt_q.push_back(1'b0);
    end
    test_program("wrap", 1'b0);
  endtask

  task automatic test_ecall();
    obs_t o;
    int en_n, ret0, hl_n;
    clr();
    ret0 = int'(retired);
    run_instr(32'h00000073, 1'b0, 1'b0, o);
    model_ret = (model_ret + 1) % 16;
    rec("ecall_cycles", o.cycles, 2);
    rec("ecall_halted", int'(o.hlt), 1);
    rec("ecall_retired", int'(o.ret), model_ret);
    rec("ecall_pc_n", o.pc_n, 0);
    en_n = 0;
    hl_n = 0;
    for (int k = 0; k < 6; k++) begin
      stall = (k % 2) == 1;
      #1;
      if ({ir_wenable, pc_wenable, rf_wenable, dm_wenable, illegal} != 0)
        en_n++;
      if (halted) hl_n++;
      @(posedge clk); #1;
    end
    stall = 1'b0;
    rec("halt_enables", en_n, 0);
    rec("halt_sticky", hl_n, 6);
    rec("halt_retired", int'(retired), (ret0 + 1) % 16);
    do_reset();
    rec("halt_cleared", int'(halted), 0);
    for (int i = 0; i < nm_q.size(); i++) begin
      total++;
      if (act_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL %s: got %0d want %0d", nm_q[i], act_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall_store();
    test_random();
    test_reset_mid();
    test_wrap();
    test_ecall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
